// File: rtl/adc_pkg.sv
// Shared definitions for the AD747x multi-channel SPI reader.
// Holds the controller state encoding and the fixed AD747x frame geometry.
package adc_pkg;

  // Every AD747x conversion is clocked out as 16 bits, MSB first.
  localparam int FRAME_BITS = 16;
  // The first four bits of each frame are always zero on a healthy device.
  localparam int LEAD_ZEROS = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_LATCH = 3'd2,
    ST_QUIET = 3'd3,
    ST_WAIT  = 3'd4
  } adc_state_t;

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK divider for the AD747x reader.
// While enable is high, sclk toggles every CLK_DIV clocks starting from low.
// rise_stb / fall_stb are high for the single clock whose edge makes sclk
// go high / low, so logic clocked on that edge sees the pre-toggle world.
// Dropping enable (or reset) returns sclk low and restarts the divider.
module adc_sclk_gen
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic i_Clk,
  input  logic i_rst_n,
  input  logic enable,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick     = enable && (div_cnt == DW'(CLK_DIV - 1));
  assign rise_stb = tick && !sclk;
  assign fall_stb = tick && sclk;

  // Divider counter and registered SCLK; held low and cleared when disabled.
  always_ff @(posedge i_Clk) begin
    if (!i_rst_n || !enable) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/adc_spi_multi.sv
// Reader for NUM_CH AD747x ADCs sharing CS_n and SCLK, one MISO per device.
// Frame sequence: IDLE -> SHIFT -> LATCH -> QUIET -> (WAIT | SHIFT | IDLE).
// Optional feature macro: ADC_SPI_MULTI_FRAME_CHK_EN adds o_frame_err, which
// flags channels whose four leading bits were not all zero.
//
// Output handshake: there is no back-pressure. o_valid is a one-clock pulse
// in the cycle o_data (and o_frame_err) take a new frame's result; o_data
// then holds until the next o_valid. o_overrun is a one-clock pulse at the
// clock where a frame is started late because i_period was below T_MIN.
module adc_spi_multi
  import adc_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int DATA_WIDTH   = 12,
  parameter int CLK_DIV      = 2,
  parameter int QUIET_CYCLES = 4,
  parameter int PERIOD_W     = 16
) (
  input  logic                         i_Clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_continuous,
  input  logic [PERIOD_W-1:0]          i_period,
  output logic                         o_busy,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_data,
  output logic                         o_valid,
  output logic                         o_overrun,
`ifdef ADC_SPI_MULTI_FRAME_CHK_EN
  output logic [NUM_CH-1:0]            o_frame_err,
`endif
  output adc_state_t                   o_state,
  output logic                         o_adc_cs_n,
  output logic                         o_adc_sclk,
  input  logic [NUM_CH-1:0]            i_adc_miso
);

  // Shortest achievable CS_n-fall to CS_n-fall spacing: the low window,
  // the LATCH clock and the quiet gap.
  localparam int T_MIN   = 2 * FRAME_BITS * CLK_DIV + 1 + QUIET_CYCLES;
  localparam int QW      = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
  localparam int BW      = $clog2(FRAME_BITS) + 1;
  localparam int TOP_BIT = FRAME_BITS - LEAD_ZEROS - 1;

  adc_state_t            state;
  logic [NUM_CH-1:0]     miso_s1;
  logic [NUM_CH-1:0]     miso_s2;
  logic [FRAME_BITS-1:0] shift_q [NUM_CH];
  logic [BW-1:0]         bit_cnt;
  logic [QW-1:0]         quiet_cnt;
  logic [PERIOD_W-1:0]   period_cnt;
  logic [PERIOD_W-1:0]   period_q;

  logic sclk_en;
  logic sclk_rise;
  logic sclk_fall;
  logic quiet_done;
  logic period_short;
  logic period_fits;
  logic period_hit;
  logic start_frame;

  assign sclk_en      = (state == ST_SHIFT);
  assign quiet_done   = (state == ST_QUIET) && (quiet_cnt == QW'(QUIET_CYCLES - 1));
  assign period_short = (32'(period_q) < 32'(T_MIN));
  // A period of exactly T_MIN is met by starting straight out of QUIET.
  assign period_fits  = (32'(period_q) <= 32'(T_MIN));
  assign period_hit   = (period_cnt == (period_q - PERIOD_W'(1)));
  assign start_frame  = ((state == ST_IDLE) && i_start)
                     || (quiet_done && i_continuous && period_fits)
                     || ((state == ST_WAIT) && i_continuous && period_hit);

  assign o_busy  = (state != ST_IDLE);
  assign o_state = state;

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .i_Clk    (i_Clk),
    .i_rst_n  (i_rst_n),
    .enable   (sclk_en),
    .sclk     (o_adc_sclk),
    .rise_stb (sclk_rise),
    .fall_stb (sclk_fall)
  );

  // Two-flop synchroniser on every MISO line.
  always_ff @(posedge i_Clk) begin
    if (!i_rst_n) begin
      miso_s1 <= '0;
      miso_s2 <= '0;
    end else begin
      miso_s1 <= i_adc_miso;
      miso_s2 <= miso_s1;
    end
  end

  // Frame controller: state, CS_n, shifting, period timing and result latch.
  always_ff @(posedge i_Clk) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      o_adc_cs_n <= 1'b1;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_overrun  <= 1'b0;
      bit_cnt    <= '0;
      quiet_cnt  <= '0;
      period_cnt <= '0;
      period_q   <= '0;
      for (int k = 0; k < NUM_CH; k++) shift_q[k] <= '0;
`ifdef ADC_SPI_MULTI_FRAME_CHK_EN
      o_frame_err <= '0;
`endif
    end else begin
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
      if (state != ST_IDLE) period_cnt <= period_cnt + PERIOD_W'(1);

      if (start_frame) begin
        // CS_n falls here; the period is captured once per frame.
        state      <= ST_SHIFT;
        o_adc_cs_n <= 1'b0;
        bit_cnt    <= '0;
        period_cnt <= '0;
        period_q   <= i_period;
        o_overrun  <= quiet_done && period_short;
        for (int k = 0; k < NUM_CH; k++) shift_q[k] <= '0;
      end else begin
        case (state)
          ST_SHIFT: begin
            if (sclk_rise) begin
              for (int k = 0; k < NUM_CH; k++)
                shift_q[k] <= {shift_q[k][FRAME_BITS-2:0], miso_s2[k]};
              bit_cnt <= bit_cnt + BW'(1);
            end
            // The falling edge after the last rise closes the frame.
            if (sclk_fall && (bit_cnt == BW'(FRAME_BITS))) begin
              state      <= ST_LATCH;
              o_adc_cs_n <= 1'b1;
            end
          end
          ST_LATCH: begin
            for (int k = 0; k < NUM_CH; k++)
              o_data[k*DATA_WIDTH +: DATA_WIDTH] <= shift_q[k][TOP_BIT -: DATA_WIDTH];
`ifdef ADC_SPI_MULTI_FRAME_CHK_EN
            for (int k = 0; k < NUM_CH; k++)
              o_frame_err[k] <= |shift_q[k][FRAME_BITS-1 -: LEAD_ZEROS];
`endif
            o_valid   <= 1'b1;
            quiet_cnt <= '0;
            state     <= ST_QUIET;
          end
          ST_QUIET: begin
            if (quiet_done) state <= i_continuous ? ST_WAIT : ST_IDLE;
            else            quiet_cnt <= quiet_cnt + QW'(1);
          end
          ST_WAIT: begin
            if (!i_continuous) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_multi.sv
// Bench for adc_spi_multi: a 2-channel 12-bit instance and a 1-channel
// 10-bit instance, each fed by a behavioural AD747x model per MISO line.
module tb_adc_spi_multi;
  import adc_pkg::*;

  localparam int EW = 2 + 24;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic [15:0] period = 16'd100;
  logic        busy, valid, overrun, cs_n, sclk;
  logic [23:0] data;
  logic [1:0]  miso;
  logic [1:0]  ferr;
  adc_state_t  st;

  logic        start10 = 1'b0;
  logic        busy10, valid10, ovr10, cs10, sclk10;
  logic [9:0]  data10;
  logic [0:0]  miso10;
  logic [0:0]  ferr10;
  adc_state_t  st10;

  adc_spi_multi #(
    .NUM_CH(2), .DATA_WIDTH(12), .CLK_DIV(2), .QUIET_CYCLES(4), .PERIOD_W(16)
  ) u_dut (
    .i_Clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_continuous (cont),
    .i_period     (period),
    .o_busy       (busy),
    .o_data       (data),
    .o_valid      (valid),
    .o_overrun    (overrun),
`ifdef ADC_SPI_MULTI_FRAME_CHK_EN
    .o_frame_err  (ferr),
`endif
    .o_state      (st),
    .o_adc_cs_n   (cs_n),
    .o_adc_sclk   (sclk),
    .i_adc_miso   (miso)
  );

  adc_spi_multi #(
    .NUM_CH(1), .DATA_WIDTH(10), .CLK_DIV(2), .QUIET_CYCLES(4), .PERIOD_W(16)
  ) u_dut10 (
    .i_Clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start10),
    .i_continuous (1'b0),
    .i_period     (16'd100),
    .o_busy       (busy10),
    .o_data       (data10),
    .o_valid      (valid10),
    .o_overrun    (ovr10),
`ifdef ADC_SPI_MULTI_FRAME_CHK_EN
    .o_frame_err  (ferr10),
`endif
    .o_state      (st10),
    .o_adc_cs_n   (cs10),
    .o_adc_sclk   (sclk10),
    .i_adc_miso   (miso10)
  );

  // ---------------- ADC models ----------------
  // Each model presents word[15] while CS_n is high and advances one bit
  // after every SCLK rise, so the next bit is stable long before it is sampled.
  logic [15:0] word0 = 16'h0000;
  logic [15:0] word1 = 16'h0000;
  logic [15:0] word10 = 16'h0000;
  logic [4:0]  rs_a = 5'd0;
  logic [4:0]  rs_b = 5'd0;

  always @(posedge sclk or posedge cs_n)
    if (cs_n) rs_a <= 5'd0; else rs_a <= rs_a + 5'd1;
  always @(posedge sclk10 or posedge cs10)
    if (cs10) rs_b <= 5'd0; else rs_b <= rs_b + 5'd1;

  function automatic logic model_bit(input logic [15:0] w, input logic [4:0] idx);
    if (idx >= 5'd16) return 1'b0;
    return w[4'(5'd15 - idx)];
  endfunction

  assign miso[0]   = model_bit(word0, rs_a);
  assign miso[1]   = model_bit(word1, rs_a);
  assign miso10[0] = model_bit(word10, rs_b);

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];     // {frame_err, data}
  logic [9:0]    exp10_q[$];
  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Event log used by the scenarios.
  int   fall_t[$];
  int   low_len[$];
  int   last_fall = 0;
  int   rise_cnt = 0;
  int   ovr_cnt = 0;
  int   valid_cnt = 0;
  int   valid10_cnt = 0;
  logic prev_cs = 1'b1;
  logic prev_sclk = 1'b0;
  logic [EW-1:0] mon_e;

  // Monitor: samples on the falling clock edge, pops expectations on o_valid.
  always @(negedge clk) begin
    if (prev_cs === 1'b1 && cs_n === 1'b0) begin
      fall_t.push_back(cyc);
      last_fall = cyc;
    end
    if (prev_cs === 1'b0 && cs_n === 1'b1) low_len.push_back(cyc - last_fall);
    if (prev_sclk === 1'b0 && sclk === 1'b1) rise_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
    if (valid === 1'b1) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_valid: got o_data %0h, required no o_valid", data);
      end else begin
        mon_e = exp_q.pop_front();
        check("o_data", 32'(data), 32'(mon_e[23:0]));
`ifdef ADC_SPI_MULTI_FRAME_CHK_EN
        check("o_frame_err", 32'(ferr), 32'(mon_e[25:24]));
`endif
      end
    end
    if (valid10 === 1'b1) begin
      valid10_cnt++;
      if (exp10_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_valid10: got o_data %0h, required no o_valid", data10);
      end else begin
        check("o_data_dw10", 32'(data10), 32'(exp10_q.pop_front()));
      end
    end
    prev_cs   = cs_n;
    prev_sclk = sclk;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_log();
    fall_t.delete();
    low_len.delete();
    rise_cnt    = 0;
    ovr_cnt     = 0;
    valid_cnt   = 0;
    valid10_cnt = 0;
  endtask

  task automatic pulse_start(input bit use10);
    @(posedge clk); #1;
    if (use10) start10 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start10 = 1'b0;
    start   = 1'b0;
  endtask

  task automatic wait_idle(input bit use10, input int budget, input string name, output int idle_at);
    bit done = 1'b0;
    idle_at = -1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!(use10 ? busy10 : busy)) begin
        done = 1'b1;
        idle_at = cyc;
      end
    end
    if (!done) begin
      chk_cnt++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic wait_falls(input int n, input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (fall_t.size() >= n) done = 1'b1;
    end
    if (!done) begin
      chk_cnt++;
      $display("FAIL %s: got %0d CS_n falls, required %0d", name, fall_t.size(), n);
    end
  endtask

  task automatic wait_rises(input int n, input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (rise_cnt >= n) done = 1'b1;
    end
    if (!done) begin
      chk_cnt++;
      $display("FAIL %s: got %0d SCLK rises, required %0d", name, rise_cnt, n);
    end
  endtask

  // Continuous run of three frames; continuous is dropped once the third
  // frame has started so that it still completes.
  task automatic run_three(input logic [15:0] per, input string name);
    int idle_at;
    period = per;
    cont   = 1'b1;
    pulse_start(1'b0);
    wait_falls(3, 400, name);
    @(posedge clk); #1;
    cont = 1'b0;
    wait_idle(1'b0, 300, name, idle_at);
    repeat (4) @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int idle_at;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(st), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Single shot: 0x0ABC / 0x0123 -> 0x123ABC. A second start mid-frame is ignored.
    word0 = 16'h0ABC;
    word1 = 16'h0123;
    exp_q.push_back({2'b00, 24'h123ABC});
    clear_log();
    pulse_start(1'b0);
    repeat (20) @(posedge clk);
    pulse_start(1'b0);
    wait_idle(1'b0, 200, "ss_idle", idle_at);
    repeat (4) @(negedge clk);
    check("ss_falls", 32'(fall_t.size()), 32'd1);
    if (low_len.size() > 0) check("ss_cs_low", 32'(low_len[0]), 32'd64);
    check("ss_rises", 32'(rise_cnt), 32'd16);
    check("ss_valids", 32'(valid_cnt), 32'd1);
    // Busy spans the 64-clock low window, LATCH and 4 quiet clocks.
    if (fall_t.size() > 0) check("ss_busy_len", 32'(idle_at - fall_t[0]), 32'd69);

    // Continuous at period 100: falls 100 apart, no overrun.
    word0 = 16'h0555;
    word1 = 16'h0FFF;
    repeat (3) exp_q.push_back({2'b00, 24'hFFF555});
    clear_log();
    run_three(16'd100, "p100");
    check("p100_falls", 32'(fall_t.size()), 32'd3);
    if (fall_t.size() >= 3) begin
      check("p100_gap1", 32'(fall_t[1] - fall_t[0]), 32'd100);
      check("p100_gap2", 32'(fall_t[2] - fall_t[1]), 32'd100);
    end
    check("p100_overrun", 32'(ovr_cnt), 32'd0);
    check("p100_valids", 32'(valid_cnt), 32'd3);
    check("p100_state", 32'(st), 32'(ST_IDLE));

    // Continuous at period 50: falls 69 apart, one overrun per late-started frame (frames 2 and 3).
    word0 = 16'h0001;
    word1 = 16'h0800;
    repeat (3) exp_q.push_back({2'b00, 24'h800001});
    clear_log();
    run_three(16'd50, "p50");
    check("p50_falls", 32'(fall_t.size()), 32'd3);
    if (fall_t.size() >= 3) begin
      check("p50_gap1", 32'(fall_t[1] - fall_t[0]), 32'd69);
      check("p50_gap2", 32'(fall_t[2] - fall_t[1]), 32'd69);
    end
    check("p50_overrun", 32'(ovr_cnt), 32'd2);
    check("p50_valids", 32'(valid_cnt), 32'd3);

    // Reset asserted at SCLK rise 8: CS_n high and SCLK low on the next edge, no o_valid.
    word0 = 16'h0321;
    word1 = 16'h0654;
    clear_log();
    pulse_start(1'b0);
    wait_rises(8, 100, "rst_rise8");
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cs_n", 32'(cs_n), 32'd1);
    check("midrst_sclk", 32'(sclk), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("midrst_data", 32'(data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_valids", 32'(valid_cnt), 32'd0);
    exp_q.push_back({2'b00, 24'h654321});
    clear_log();
    pulse_start(1'b0);
    wait_idle(1'b0, 200, "post_rst_idle", idle_at);
    repeat (4) @(negedge clk);
    if (low_len.size() > 0) check("post_rst_cs_low", 32'(low_len[0]), 32'd64);
    check("post_rst_valids", 32'(valid_cnt), 32'd1);

    // Channel 1 with a non-zero leading bit: data still 0x123456, frame error 2'b10.
    word0 = 16'h0456;
    word1 = 16'h8123;
    exp_q.push_back({2'b10, 24'h123456});
    clear_log();
    pulse_start(1'b0);
    wait_idle(1'b0, 200, "ferr_idle", idle_at);
    repeat (4) @(negedge clk);

    // 10-bit build: stream 0000_1010101010_00 -> 0x2AA.
    word10 = 16'h0AA8;
    exp10_q.push_back(10'h2AA);
    clear_log();
    pulse_start(1'b1);
    wait_idle(1'b1, 200, "dw10_idle", idle_at);
    repeat (4) @(negedge clk);
    check("dw10_valids", 32'(valid10_cnt), 32'd1);

    // Every expected result must have been consumed.
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("exp10_q_empty", 32'(exp10_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
